// File: rtl/router_rx_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | router_rx_pkg : shared types for the router output-lane receiver   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package router_rx_pkg;

  localparam int BYTE_W = 8;

  typedef struct packed {
    logic              err;
    logic              last;
    logic [BYTE_W-1:0] data;
  } rx_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    DROP = 2'd2
  } rx_state_e;

  localparam rx_entry_t TERM_ENTRY = '{err: 1'b1, last: 1'b1, data: 8'h00};

endpackage
`default_nettype wire

// File: rtl/router_rx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | router_rx_fifo : synchronous show-ahead FIFO of rx_entry_t         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module router_rx_fifo
  import router_rx_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  rx_entry_t              push_entry,
  input  logic                   pop,
  output rx_entry_t              head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  rx_entry_t     mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          do_push, do_pop;

  always_comb begin
    full     = (level_q == (AW+1)'(DEPTH));
    empty    = (level_q == '0);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
    head  = mem_q[rd_ptr_q];
    level = level_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset; the head is masked by empty at the top level.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry;
  end

endmodule
`default_nettype wire

// File: rtl/router_port_rx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | router_port_rx : serial lane deserializer with byte-stream FIFO    |
// | Optional ROUTER_RX_STATS_EN adds pkt_cnt/err_cnt.  Rev 1.0         |
// +--------------------------------------------------------------------+
module router_port_rx
  import router_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_BYTES  = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        dout,
  input  logic                        valido_n,
  input  logic                        frameo_n,
  output logic [BYTE_W-1:0]           m_data,
  output logic                        m_last,
  output logic                        m_err,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        ovf_pulse,
  output logic                        frm_err_pulse
`ifdef ROUTER_RX_STATS_EN
  ,
  output logic [15:0]                 pkt_cnt,
  output logic [15:0]                 err_cnt
`endif
);

  localparam int BCW = $clog2(MAX_BYTES + 1);

  rx_state_e      state_q, state_d;
  logic [2:0]     bitcnt_q, bitcnt_d;
  logic [6:0]     shreg_q, shreg_d;
  logic [BCW-1:0] bytecnt_q, bytecnt_d;
  logic           pending_term_q, pending_term_d;
  logic           ovf_q, ovf_d;
  logic           frm_err_q, frm_err_d;

  logic           bit_in;
  logic           term_req;
  logic           term_push;
  logic           byte_push;
  rx_entry_t      byte_entry;
  rx_entry_t      push_entry;
  rx_entry_t      head;
  logic           fifo_full, fifo_empty;

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shreg_d    = shreg_q;
    bytecnt_d  = bytecnt_q;
    ovf_d      = 1'b0;
    frm_err_d  = 1'b0;
    term_req   = pending_term_q;
    byte_push  = 1'b0;
    byte_entry = '0;
    bit_in     = !valido_n;

    case (state_q)
      IDLE: begin
        if (bit_in && !frameo_n) begin
          shreg_d    = '0;
          shreg_d[0] = dout;
          bitcnt_d   = 3'd1;
          bytecnt_d  = '0;
          // An undelivered terminator blocks the whole next frame.
          state_d    = pending_term_q ? DROP : DATA;
        end else if (bit_in && frameo_n) begin
          frm_err_d = 1'b1;
          term_req  = 1'b1;
        end
      end

      DATA: begin
        if (!bit_in) begin
          if (frameo_n) begin
            frm_err_d = 1'b1;
            term_req  = 1'b1;
            state_d   = IDLE;
            bitcnt_d  = '0;
            bytecnt_d = '0;
          end
        end else if (bytecnt_q == BCW'(MAX_BYTES)) begin
          ovf_d     = 1'b1;
          bitcnt_d  = '0;
          bytecnt_d = '0;
          if (frameo_n) begin
            term_req = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d  = DROP;
          end
        end else if (bitcnt_q == 3'd7) begin
          byte_entry = '{err: 1'b0, last: frameo_n, data: {dout, shreg_q}};
          bitcnt_d   = '0;
          if (fifo_full) begin
            ovf_d     = 1'b1;
            bytecnt_d = '0;
            if (frameo_n) begin
              term_req = 1'b1;
              state_d  = IDLE;
            end else begin
              state_d  = DROP;
            end
          end else begin
            byte_push = 1'b1;
            if (frameo_n) begin
              bytecnt_d = '0;
              state_d   = IDLE;
            end else begin
              bytecnt_d = bytecnt_q + BCW'(1);
            end
          end
        end else begin
          shreg_d[bitcnt_q] = dout;
          bitcnt_d          = bitcnt_q + 3'd1;
          if (frameo_n) begin
            frm_err_d = 1'b1;
            term_req  = 1'b1;
            state_d   = IDLE;
            bitcnt_d  = '0;
            bytecnt_d = '0;
          end
        end
      end

      DROP: begin
        if (frameo_n) begin
          term_req  = 1'b1;
          state_d   = IDLE;
          bitcnt_d  = '0;
          bytecnt_d = '0;
        end
      end

      default: state_d = IDLE;
    endcase

    term_push      = term_req && !fifo_full && !byte_push;
    pending_term_d = term_req && !term_push;
    push_entry     = term_push ? TERM_ENTRY : byte_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      bitcnt_q       <= '0;
      shreg_q        <= '0;
      bytecnt_q      <= '0;
      pending_term_q <= 1'b0;
      ovf_q          <= 1'b0;
      frm_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      bitcnt_q       <= bitcnt_d;
      shreg_q        <= shreg_d;
      bytecnt_q      <= bytecnt_d;
      pending_term_q <= pending_term_d;
      ovf_q          <= ovf_d;
      frm_err_q      <= frm_err_d;
    end
  end

  router_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (byte_push || term_push),
    .push_entry (push_entry),
    .pop        (m_ready),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .level      (level)
  );

  always_comb begin
    m_valid       = !fifo_empty;
    m_data        = fifo_empty ? '0   : head.data;
    m_last        = fifo_empty ? 1'b0 : head.last;
    m_err         = fifo_empty ? 1'b0 : head.err;
    ovf_pulse     = ovf_q;
    frm_err_pulse = frm_err_q;
  end

`ifdef ROUTER_RX_STATS_EN
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    err_cnt_d = err_cnt_q;
    if (byte_push && byte_entry.last && (pkt_cnt_q != 16'hFFFF))
      pkt_cnt_d = pkt_cnt_q + 16'd1;
    if (term_push && (err_cnt_q != 16'hFFFF))
      err_cnt_d = err_cnt_q + 16'd1;
    pkt_cnt = pkt_cnt_q;
    err_cnt = err_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end
`endif

endmodule
`default_nettype wire
